// File: rtl/ram_serial_if.sv
// Serial external-RAM read port: shifts a word address out over RAM_PINS pins,
// waits a fixed turnaround, then shifts the returned word back in.
module ram_serial_if #(
  parameter int RAM_PINS        = 4,
  parameter int RAM_LOG2_CYCLES = 2,
  parameter int READ_LATENCY    = 2,
  localparam int WORD_BITS      = RAM_PINS << RAM_LOG2_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WORD_BITS-1:0] req_addr,
  output logic [RAM_PINS-1:0]  addr_pins,
  input  logic [RAM_PINS-1:0]  data_pins,
  output logic                 rsp_valid,
  output logic [WORD_BITS-1:0] rsp_data,
  output logic                 busy
);

  localparam int LAT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;

  state_t                     state, state_next;
  logic [RAM_LOG2_CYCLES-1:0] beat, beat_next;
  logic [LAT_W-1:0]           lat, lat_next;
  logic [WORD_BITS-1:0]       addr_sr;
  logic [WORD_BITS-1:0]       word_sr;
  logic                       last_beat;
  logic                       accept;

  assign last_beat = (beat == '1);
  assign req_ready = (state == IDLE) || ((state == DATA) && last_beat);
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign addr_pins = (state == ADDR) ? addr_sr[RAM_PINS-1:0] : '0;

  always_comb begin
    state_next = state;
    beat_next  = beat;
    lat_next   = lat;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ADDR;
          beat_next  = '0;
        end
      end
      ADDR: begin
        beat_next = beat + 1'b1;
        if (last_beat) begin
          beat_next  = '0;
          lat_next   = '0;
          state_next = (READ_LATENCY > 0) ? WAIT : DATA;
        end
      end
      WAIT: begin
        lat_next = lat + 1'b1;
        if (lat == LAT_LAST) begin
          lat_next   = '0;
          beat_next  = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        beat_next = beat + 1'b1;
        if (last_beat) begin
          beat_next  = '0;
          state_next = accept ? ADDR : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
        lat_next   = '0;
      end
    endcase
  end

  // Address leaves LSB group first; data enters at the top so group 0 ends at the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      lat       <= '0;
      addr_sr   <= '0;
      word_sr   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_next;
      beat      <= beat_next;
      lat       <= lat_next;
      rsp_valid <= 1'b0;
      if (accept)
        addr_sr <= req_addr;
      else if (state == ADDR)
        addr_sr <= addr_sr >> RAM_PINS;
      if (state == DATA) begin
        word_sr <= {data_pins, word_sr[WORD_BITS-1:RAM_PINS]};
        if (last_beat) begin
          rsp_valid <= 1'b1;
          rsp_data  <= {data_pins, word_sr[WORD_BITS-1:RAM_PINS]};
        end
      end
    end
  end

endmodule
